vproc_dispatcher: RTL and testbench
===================================

// Module: vproc_dispatcher
// PURPOSE
//  Single-issue dispatcher between the decoder and the execution units (LSU, ALU, MUL, SLD, ELEM).
//  Buffers one decoded instruction and tracks pending vreg reads/writes to block RAW/WAW/WAR hazards.
//  Routes the instruction to the unit given by its op_unit; UNIT_CFG instructions go to the CFG port
//  only after the whole vector pipeline has drained.
// PARAMETERS
//  ID_W      3   width of instruction id tag forwarded to units
//  VREG_CNT  32  number of architectural vregs (width of hazard masks)
// PORTS
//  clk_i            in   1             clock, all logic on rising edge
//  sync_rst_ni      in   1             synchronous reset, active low
//  instr_valid_i    in   1             decoded instruction valid
//  instr_ready_o    out  1             dispatcher can accept instruction
//  instr_unit_i     in   op_unit       target unit
//  instr_mode_i     in   op_mode       operation mode
//  instr_rs1_i      in   op_regs       source 1
//  instr_rs2_i      in   op_regs       source 2
//  instr_vd_i       in   op_regd       destination
//  instr_id_i       in   ID_W          id tag
//  instr_rd_mask_i  in   VREG_CNT      vregs read (LMUL/EMUL-expanded by decoder)
//  instr_wr_mask_i  in   VREG_CNT      vregs written
//  unit_valid_o     out  UNIT_CNT      one-hot dispatch valid, index = op_unit
//  unit_ready_i     in   UNIT_CNT      per-unit accept
//  unit_mode_o/rs1_o/rs2_o/vd_o/id_o  out  shared  broadcast fields of held instruction
//  unit_busy_i      in   UNIT_CNT      unit has work in flight
//  vreg_rd_clr_i    in   VREG_CNT      vregs whose last pending read completed
//  vreg_wr_clr_i    in   VREG_CNT      vregs whose pending write completed
//  cfg_valid_o      out  1             CFG instruction valid
//  cfg_ready_i      in   1             CFG handler accept
//  pend_wr_o        out  VREG_CNT      current pending-write mask
//  illegal_o        out  1             1-cycle pulse: instruction with unit > UNIT_CFG dropped
//  stall_cnt_o      out  32            stall counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset: FSM=EMPTY, holding reg invalid, pend_rd=pend_wr=0; all valid outputs, illegal_o, stall_cnt_o = 0.
//  FSM: EMPTY -(accept, unit<UNIT_CFG)-> HOLD; EMPTY -(accept, UNIT_CFG)-> DRAIN;
//       HOLD -(dispatch handshake, no new accept)-> EMPTY; DRAIN -(cfg handshake)-> EMPTY.
//  instr_ready_o = EMPTY | (HOLD & unit handshake this cycle); back-to-back 1 instr/cycle when hazard-free.
//  Accept-to-unit_valid_o latency 1 cycle (registered holding stage); no combinational in->out path.
//  hazard = |(rd_mask & pend_wr) | |(wr_mask & (pend_wr | pend_rd)).
//  HOLD: unit_valid_o[unit] = ~hazard; once asserted stays high until handshake (masks only shrink meanwhile).
//  Dispatch handshake: pend_rd |= rd_mask, pend_wr |= wr_mask.
//  Clear: pend_x &= ~clr; same-cycle set and clear of one bit -> set wins. Clear of unset bit: no effect.
//  DRAIN: cfg_valid_o = (unit_busy_i==0) & (pend_rd==0) & (pend_wr==0); held until cfg_ready_i.
//  CFG instructions do not touch pend masks. No instruction accepted while DRAIN.
//  unit > UNIT_CFG on accept: not stored, illegal_o=1 next cycle, FSM stays EMPTY.
//  Sync reset mid-dispatch: in-flight holding reg discarded; valid outputs low from the next edge.
// CONFIGURATION
//  VPROC_DISPATCH_PERF_EN defined: stall_cnt_o counts cycles in HOLD/DRAIN with no handshake; saturates
//  at 32'hFFFF_FFFF; cleared by reset. Undefined: counter not built, stall_cnt_o tied to 0.
// STRUCTURE
//  vproc_pkg: add disp_state_e {DISP_EMPTY, DISP_HOLD, DISP_DRAIN}, parameter VREG_CNT = 32.
//  Sub-module vproc_vreg_tracker: pend_rd/pend_wr regs, set/clear logic, hazard output; instantiated once.
//  Top: FSM, holding reg, unit routing, optional counter.
// TESTING
//  1. ALU instr vd=v4 wr_mask=0x10, then ALU rd_mask=0x10 -> 2nd valid held low until vreg_wr_clr_i[4].
//  2. wr_mask=0x0F dispatched, same cycle clr=0x01 plus new set 0x01 -> pend_wr_o stays 0x0F.
//  3. CFG after MUL with unit_busy_i[MUL]=1 -> cfg_valid_o=0 until busy=0 and masks 0, then 1 next cycle.
//  4. 4 independent instrs, all unit_ready_i=1 -> one dispatch per cycle, instr_ready_o never drops.
//  5. unit=3'b110 -> illegal_o pulses 1 cycle, no unit_valid_o, ready stays high.
//  6. Reset in HOLD with unit_ready_i=0 -> unit_valid_o=0, pend masks 0, stall_cnt_o=0 after edge.

Source files
------------

// File: rtl/vproc_pkg.sv
// vproc_pkg: shared unit/operand types, vreg count and dispatcher states for the vector processor
package vproc_pkg;
  parameter int VREG_CNT = 32;
  localparam int UNIT_CNT = 5;
  typedef enum logic [2:0] {UNIT_LSU, UNIT_ALU, UNIT_MUL, UNIT_SLD, UNIT_ELEM, UNIT_CFG} op_unit;
  typedef struct packed {
    logic [3:0] op;
    logic       masked;
    logic [1:0] emul;
  } op_mode;
  typedef struct packed {
    logic       vreg;
    logic [4:0] r;
  } op_regs;
  typedef struct packed {
    logic       vreg;
    logic [4:0] addr;
  } op_regd;
  typedef enum logic [1:0] {DISP_EMPTY, DISP_HOLD, DISP_DRAIN} disp_state_e;
  function automatic logic unit_legal(input op_unit u);
    return u <= UNIT_CFG;
  endfunction
endpackage

// File: rtl/vproc_vreg_tracker.sv
// vproc_vreg_tracker: pending vreg read/write masks and RAW/WAW/WAR hazard check for one instruction
module vproc_vreg_tracker #(
  parameter int VREG_CNT = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  logic [VREG_CNT-1:0] rd_mask,
  input  logic [VREG_CNT-1:0] wr_mask,
  input  logic [VREG_CNT-1:0] rd_clr,
  input  logic [VREG_CNT-1:0] wr_clr,
  output logic [VREG_CNT-1:0] pend_rd,
  output logic [VREG_CNT-1:0] pend_wr,
  output logic                hazard
);
  // set is applied after clear so a same-cycle set wins
  always_ff @(posedge clk)
    if (!rst_n) begin
      pend_rd <= '0;
      pend_wr <= '0;
    end else begin
      pend_rd <= (pend_rd & ~rd_clr) | (set_en ? rd_mask : '0);
      pend_wr <= (pend_wr & ~wr_clr) | (set_en ? wr_mask : '0);
    end
  assign hazard = |(rd_mask & pend_wr) | |(wr_mask & (pend_wr | pend_rd));
endmodule

// File: rtl/vproc_dispatcher.sv
// vproc_dispatcher: single-issue hazard-checked dispatch to vector units and drained CFG issue.
// Define VPROC_DISPATCH_PERF_EN to build the saturating stall counter.
module vproc_dispatcher import vproc_pkg::*; #(
  parameter int ID_W     = 3,
  parameter int VREG_CNT = vproc_pkg::VREG_CNT
) (
  input  logic                clk_i,
  input  logic                sync_rst_ni,
  input  logic                instr_valid_i,
  output logic                instr_ready_o,
  input  op_unit              instr_unit_i,
  input  op_mode              instr_mode_i,
  input  op_regs              instr_rs1_i,
  input  op_regs              instr_rs2_i,
  input  op_regd              instr_vd_i,
  input  logic [ID_W-1:0]     instr_id_i,
  input  logic [VREG_CNT-1:0] instr_rd_mask_i,
  input  logic [VREG_CNT-1:0] instr_wr_mask_i,
  output logic [UNIT_CNT-1:0] unit_valid_o,
  input  logic [UNIT_CNT-1:0] unit_ready_i,
  output op_mode              unit_mode_o,
  output op_regs              unit_rs1_o,
  output op_regs              unit_rs2_o,
  output op_regd              unit_vd_o,
  output logic [ID_W-1:0]     unit_id_o,
  input  logic [UNIT_CNT-1:0] unit_busy_i,
  input  logic [VREG_CNT-1:0] vreg_rd_clr_i,
  input  logic [VREG_CNT-1:0] vreg_wr_clr_i,
  output logic                cfg_valid_o,
  input  logic                cfg_ready_i,
  output logic [VREG_CNT-1:0] pend_wr_o,
  output logic                illegal_o,
  output logic [31:0]         stall_cnt_o
);
  typedef struct packed {
    op_unit              unit;
    op_mode              mode;
    op_regs              rs1;
    op_regs              rs2;
    op_regd              vd;
    logic [ID_W-1:0]     id;
    logic [VREG_CNT-1:0] rd_mask;
    logic [VREG_CNT-1:0] wr_mask;
  } hold_t;
  disp_state_e         state, state_nxt;
  hold_t               hold;
  logic [VREG_CNT-1:0] pend_rd;
  logic                hazard, disp_hs, cfg_hs, accept, legal;
  assign legal = unit_legal(instr_unit_i);
  always_ff @(posedge clk_i)
    if (!sync_rst_ni) state <= DISP_EMPTY;
    else state <= state_nxt;
  always_comb
    state_nxt = (accept && instr_unit_i == UNIT_CFG) ? DISP_DRAIN :
                (accept && legal)                    ? DISP_HOLD  :
                (disp_hs || cfg_hs)                  ? DISP_EMPTY : state;
  // pend masks only shrink while an instruction waits, so a raised valid cannot drop before handshake
  always_comb begin
    unit_valid_o  = (state == DISP_HOLD && !hazard) ? UNIT_CNT'(1) << hold.unit : '0;
    cfg_valid_o   = state == DISP_DRAIN && !(|unit_busy_i) && !(|pend_rd) && !(|pend_wr_o);
    disp_hs       = |(unit_valid_o & unit_ready_i);
    cfg_hs        = cfg_valid_o && cfg_ready_i;
    instr_ready_o = state == DISP_EMPTY || disp_hs;
    accept        = instr_valid_i && instr_ready_o;
  end
  always_ff @(posedge clk_i)
    if (!sync_rst_ni) begin
      hold      <= '0;
      illegal_o <= 1'b0;
    end else begin
      illegal_o <= accept && !legal;
      if (accept && legal)
        hold <= '{unit: instr_unit_i, mode: instr_mode_i, rs1: instr_rs1_i, rs2: instr_rs2_i,
                  vd: instr_vd_i, id: instr_id_i, rd_mask: instr_rd_mask_i, wr_mask: instr_wr_mask_i};
    end
  assign unit_mode_o = hold.mode;
  assign unit_rs1_o  = hold.rs1;
  assign unit_rs2_o  = hold.rs2;
  assign unit_vd_o   = hold.vd;
  assign unit_id_o   = hold.id;
  vproc_vreg_tracker #(.VREG_CNT(VREG_CNT)) u_tracker (
    .clk     (clk_i),
    .rst_n   (sync_rst_ni),
    .set_en  (disp_hs),
    .rd_mask (hold.rd_mask),
    .wr_mask (hold.wr_mask),
    .rd_clr  (vreg_rd_clr_i),
    .wr_clr  (vreg_wr_clr_i),
    .pend_rd (pend_rd),
    .pend_wr (pend_wr_o),
    .hazard  (hazard)
  );
`ifdef VPROC_DISPATCH_PERF_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk_i)
    if (!sync_rst_ni) stall_q <= '0;
    else if (state != DISP_EMPTY && !disp_hs && !cfg_hs && stall_q != '1) stall_q <= stall_q + 32'd1;
  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_vproc_dispatcher.sv
// tb_vproc_dispatcher: directed stimulus with a scoreboard of expected dispatch/cfg/illegal events
module tb_vproc_dispatcher;
  import vproc_pkg::*;
  localparam int K_DISP = 0, K_CFG = 1, K_ILL = 2;
  typedef struct {
    int         kind;
    logic [2:0] unit;
    logic [2:0] id;
  } exp_t;
  logic                clk = 1'b0;
  logic                sync_rst_ni = 1'b0;
  logic                instr_valid_i = 1'b0;
  logic                instr_ready_o;
  op_unit              instr_unit_i = UNIT_LSU;
  op_mode              instr_mode_i = '0;
  op_regs              instr_rs1_i = '0, instr_rs2_i = '0;
  op_regd              instr_vd_i = '0;
  logic [2:0]          instr_id_i = '0;
  logic [31:0]         instr_rd_mask_i = '0, instr_wr_mask_i = '0;
  logic [4:0]          unit_valid_o;
  logic [4:0]          unit_ready_i = '0;
  op_mode              unit_mode_o;
  op_regs              unit_rs1_o, unit_rs2_o;
  op_regd              unit_vd_o;
  logic [2:0]          unit_id_o;
  logic [4:0]          unit_busy_i = '0;
  logic [31:0]         vreg_rd_clr_i = '0, vreg_wr_clr_i = '0;
  logic                cfg_valid_o;
  logic                cfg_ready_i = 1'b0;
  logic [31:0]         pend_wr_o;
  logic                illegal_o;
  logic [31:0]         stall_cnt_o;
  int                  tests = 0, fails = 0;
  exp_t                sb[$];

  vproc_dispatcher #(.ID_W(3), .VREG_CNT(32)) dut (
    .clk_i(clk), .sync_rst_ni(sync_rst_ni), .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .instr_unit_i(instr_unit_i), .instr_mode_i(instr_mode_i), .instr_rs1_i(instr_rs1_i),
    .instr_rs2_i(instr_rs2_i), .instr_vd_i(instr_vd_i), .instr_id_i(instr_id_i),
    .instr_rd_mask_i(instr_rd_mask_i), .instr_wr_mask_i(instr_wr_mask_i), .unit_valid_o(unit_valid_o),
    .unit_ready_i(unit_ready_i), .unit_mode_o(unit_mode_o), .unit_rs1_o(unit_rs1_o), .unit_rs2_o(unit_rs2_o),
    .unit_vd_o(unit_vd_o), .unit_id_o(unit_id_o), .unit_busy_i(unit_busy_i), .vreg_rd_clr_i(vreg_rd_clr_i),
    .vreg_wr_clr_i(vreg_wr_clr_i), .cfg_valid_o(cfg_valid_o), .cfg_ready_i(cfg_ready_i),
    .pend_wr_o(pend_wr_o), .illegal_o(illegal_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_cmp(input int k);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event: got kind %0d expected none", k);
      return;
    end
    e = sb.pop_front();
    check("sb_kind", 32'(k), 32'(e.kind));
    if (k == K_DISP) check("sb_unit_onehot", 32'(unit_valid_o), 32'(5'd1 << e.unit));
    if (k != K_ILL) begin
      check("sb_id", 32'(unit_id_o), 32'(e.id));
      check("sb_vd", 32'(unit_vd_o.addr), 32'(e.id) * 2);
    end
  endtask

  always @(negedge clk) begin
    if (|(unit_valid_o & unit_ready_i)) pop_cmp(K_DISP);
    if (cfg_valid_o && cfg_ready_i) pop_cmp(K_CFG);
    if (illegal_o) pop_cmp(K_ILL);
  end

  task automatic send(input logic [2:0] u, input logic [2:0] id, input logic [31:0] rd,
                      input logic [31:0] wr, output int n);
    exp_t e;
    n = 0;
    instr_valid_i = 1'b1;
    instr_unit_i = op_unit'(u);
    instr_id_i = id;
    instr_rd_mask_i = rd;
    instr_wr_mask_i = wr;
    instr_mode_i = op_mode'({4'(id), 3'b0});
    instr_rs1_i = '{vreg: 1'b1, r: 5'(id) + 5'd1};
    instr_rs2_i = '{vreg: 1'b0, r: 5'(id) + 5'd2};
    instr_vd_i = '{vreg: 1'b1, addr: 5'(id) * 5'd2};
    @(negedge clk);
    while (!instr_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: instr_ready_o %b after %0d cycles, expected 1", instr_ready_o, n);
    end else begin
      e.kind = u > 3'd5 ? K_ILL : (u == 3'd5 ? K_CFG : K_DISP);
      e.unit = u;
      e.id = id;
      sb.push_back(e);
      step();
    end
    instr_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) step();
    @(negedge clk);
    check("rst_unit_valid", 32'(unit_valid_o), 0);
    check("rst_cfg_valid", 32'(cfg_valid_o), 0);
    check("rst_illegal", 32'(illegal_o), 0);
    check("rst_pend_wr", pend_wr_o, 0);
    check("rst_stall", stall_cnt_o, 0);
    check("rst_ready", 32'(instr_ready_o), 1);
    step();
    sync_rst_ni = 1'b1;
    unit_ready_i = '1;
    cfg_ready_i = 1'b1;
    step();
    // RAW on v4: second ALU waits for the write clear
    send(3'd1, 3'd1, 32'h0, 32'h10, n);
    send(3'd1, 3'd2, 32'h10, 32'h0, n);
    repeat (3) begin
      @(negedge clk);
      check("raw_blocked_valid", 32'(unit_valid_o), 0);
      check("raw_pend_wr", pend_wr_o, 32'h10);
    end
    step();
    vreg_wr_clr_i = 32'h10;
    step();
    vreg_wr_clr_i = '0;
    @(negedge clk);
    check("raw_released_valid", 32'(unit_valid_o), 32'h2);
    check("raw_pend_cleared", pend_wr_o, 0);
    step();
    // set beats a same-cycle clear of the same bit
    send(3'd1, 3'd3, 32'h0, 32'h0F, n);
    vreg_wr_clr_i = 32'h01;
    step();
    vreg_wr_clr_i = '0;
    check("set_wins_pend_wr", pend_wr_o, 32'h0F);
    vreg_wr_clr_i = 32'h03;
    step();
    check("partial_clear", pend_wr_o, 32'h0C);
    vreg_wr_clr_i = '1;
    vreg_rd_clr_i = '1;
    step();
    vreg_wr_clr_i = '0;
    vreg_rd_clr_i = '0;
    check("clear_all", pend_wr_o, 0);
    // CFG waits for MUL busy and the pending write to drain
    unit_busy_i = 5'b00100;
    send(3'd2, 3'd4, 32'h0, 32'h100, n);
    send(3'd5, 3'd5, 32'h0, 32'h0, n);
    repeat (2) begin
      @(negedge clk);
      check("drain_busy_cfg_valid", 32'(cfg_valid_o), 0);
      check("drain_no_accept", 32'(instr_ready_o), 0);
      check("drain_no_unit_valid", 32'(unit_valid_o), 0);
    end
    step();
    unit_busy_i = '0;
    @(negedge clk);
    check("drain_pend_cfg_valid", 32'(cfg_valid_o), 0);
    step();
    vreg_wr_clr_i = 32'h100;
    step();
    vreg_wr_clr_i = '0;
    @(negedge clk);
    check("drain_done_cfg_valid", 32'(cfg_valid_o), 1);
    step();
    // back-to-back independent instructions
    send(3'd0, 3'd0, 32'h0, 32'h0010_0000, n);
    check("b2b_wait0", 32'(n), 0);
    send(3'd1, 3'd1, 32'h0, 32'h0020_0000, n);
    check("b2b_wait1", 32'(n), 0);
    send(3'd3, 3'd3, 32'h0, 32'h0040_0000, n);
    check("b2b_wait2", 32'(n), 0);
    send(3'd4, 3'd6, 32'h0, 32'h0080_0000, n);
    check("b2b_wait3", 32'(n), 0);
    step();
    check("b2b_all_dispatched", 32'(sb.size()), 0);
    check("b2b_pend_wr", pend_wr_o, 32'h00F0_0000);
    vreg_wr_clr_i = '1;
    step();
    vreg_wr_clr_i = '0;
    // illegal unit is dropped with a one-cycle pulse
    send(3'd6, 3'd2, 32'h0, 32'h0, n);
    @(negedge clk);
    check("illegal_pulse", 32'(illegal_o), 1);
    check("illegal_no_unit_valid", 32'(unit_valid_o), 0);
    check("illegal_ready", 32'(instr_ready_o), 1);
    step();
    @(negedge clk);
    check("illegal_pulse_end", 32'(illegal_o), 0);
    step();
    // reset while an instruction is held and stalled
    send(3'd1, 3'd4, 32'h0, 32'h4000_0000, n);
    send(3'd0, 3'd7, 32'h0, 32'h3, n);
    unit_ready_i = '0;
    @(negedge clk);
    check("hold_unit_valid", 32'(unit_valid_o), 32'h1);
    check("hold_pend_wr", pend_wr_o, 32'h4000_0000);
    step();
    step();
`ifdef VPROC_DISPATCH_PERF_EN
    check("stall_counting", 32'(stall_cnt_o != 0), 1);
`else
    check("stall_tied_off", stall_cnt_o, 0);
`endif
    sync_rst_ni = 1'b0;
    sb.delete();
    step();
    @(negedge clk);
    check("rst_hold_unit_valid", 32'(unit_valid_o), 0);
    check("rst_hold_pend_wr", pend_wr_o, 0);
    check("rst_hold_stall", stall_cnt_o, 0);
    check("rst_hold_cfg_valid", 32'(cfg_valid_o), 0);
    step();
    sync_rst_ni = 1'b1;
    step();
    @(negedge clk);
    check("post_rst_ready", 32'(instr_ready_o), 1);
    check("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
